// File: rtl/spi_frame_sequencer_if.sv
// Byte/register-file side signals of the SPI frame sequencer.
// slave = sequencer side, master = deserializer/register-file/shifter side.
interface spi_frame_sequencer_if;
    logic       frame_end;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic       busy;
    logic [7:0] byte_cnt;
    logic       err_addr;
    logic       err_underrun;
    logic       err_clr;

    modport slave (
        input  frame_end, byte_valid, byte_data, rd_ack, rd_data, err_clr,
        output wr_en, wr_addr, wr_data, rd_req, rd_addr, tx_byte, tx_load,
               busy, byte_cnt, err_addr, err_underrun
    );

    modport master (
        output frame_end, byte_valid, byte_data, rd_ack, rd_data, err_clr,
        input  wr_en, wr_addr, wr_data, rd_req, rd_addr, tx_byte, tx_load,
               busy, byte_cnt, err_addr, err_underrun
    );
endinterface

// File: rtl/spi_frame_sequencer.sv
// Command-byte decoder: auto-incrementing register writes / read fetches for the SPI peripheral.
// Write strobe 1 cycle after byte; tx_load 1 cycle after rd_ack; rd_req held until rd_ack, underrun flagged on early byte.
module spi_frame_sequencer #(
    parameter logic [7:0] MAX_ADDR  = 8'd59,
    parameter logic [7:0] FILL_BYTE = 8'hFF
) (
    input  logic                    sclk,
    input  logic                    rstn,
    spi_frame_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, WRITE, RD_REQ, RD_HOLD} state_t;

    state_t     state_q, state_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic       tx_load_q, tx_load_d;
    logic       err_addr_q, err_addr_d;
    logic       err_under_q, err_under_d;
    logic       set_addr, set_under;
    logic [7:0] cnt_inc;
    logic [7:0] ptr_next;
    logic       ptr_ok;

    // Address 0 is reserved, so the pointer wraps to 1 rather than 0.
    assign ptr_next = (ptr_q >= MAX_ADDR) ? 8'd1 : ptr_q + 8'd1;
    assign ptr_ok   = (ptr_q != 8'd0) && (ptr_q <= MAX_ADDR);
    assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        tx_byte_d = tx_byte_q;
        tx_load_d = 1'b0;
        set_addr  = 1'b0;
        set_under = 1'b0;
        if (bus.frame_end) begin
            state_d = IDLE;
            ptr_d   = 8'd0;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.byte_valid) begin
                        ptr_d   = {1'b0, bus.byte_data[6:0]};
                        cnt_d   = 8'd0;
                        state_d = bus.byte_data[7] ? RD_REQ : WRITE;
                    end
                end
                WRITE: begin
                    if (bus.byte_valid) begin
                        if (ptr_ok) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = bus.byte_data;
                        end else begin
                            set_addr = 1'b1;
                        end
                        ptr_d = ptr_next;
                        cnt_d = cnt_inc;
                    end
                end
                RD_REQ: begin
                    if (!ptr_ok) begin
                        tx_byte_d = FILL_BYTE;
                        tx_load_d = 1'b1;
                        set_addr  = 1'b1;
                        ptr_d     = ptr_next;
                        state_d   = RD_HOLD;
                        if (bus.byte_valid) cnt_d = cnt_inc;
                    end else if (bus.rd_ack) begin
                        tx_byte_d = bus.rd_data;
                        tx_load_d = 1'b1;
                        ptr_d     = ptr_next;
                        state_d   = RD_HOLD;
                        if (bus.byte_valid) cnt_d = cnt_inc;
                    end else if (bus.byte_valid) begin
                        // Shifter needs a byte now; skip this address and keep requesting the next.
                        set_under = 1'b1;
                        tx_byte_d = FILL_BYTE;
                        tx_load_d = 1'b1;
                        ptr_d     = ptr_next;
                        cnt_d     = cnt_inc;
                    end
                end
                RD_HOLD: begin
                    if (bus.byte_valid) begin
                        cnt_d   = cnt_inc;
                        state_d = RD_REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        err_addr_d  = set_addr  | (err_addr_q  & ~bus.err_clr);
        err_under_d = set_under | (err_under_q & ~bus.err_clr);
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            ptr_q       <= 8'd0;
            cnt_q       <= 8'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 8'd0;
            wr_data_q   <= 8'd0;
            tx_byte_q   <= 8'd0;
            tx_load_q   <= 1'b0;
            err_addr_q  <= 1'b0;
            err_under_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            tx_byte_q   <= tx_byte_d;
            tx_load_q   <= tx_load_d;
            err_addr_q  <= err_addr_d;
            err_under_q <= err_under_d;
        end
    end

    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.rd_req       = (state_q == RD_REQ) && ptr_ok;
    assign bus.rd_addr      = ptr_q;
    assign bus.tx_byte      = tx_byte_q;
    assign bus.tx_load      = tx_load_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.byte_cnt     = cnt_q;
    assign bus.err_addr     = err_addr_q;
    assign bus.err_underrun = err_under_q;

endmodule

// File: doc/spi_frame_sequencer.md
# spi_frame_sequencer

Byte-level transaction controller for the SPI peripheral. It sits between the serial deserializer, which delivers whole received bytes, and the register file. The first byte of each frame is a command byte: R/W flag plus 7-bit start address. The block then generates auto-incrementing write strobes or read fetch requests, and loads the readback byte for the serial output shifter. It also flags invalid addresses and read underruns.

## Interface
- MAX_ADDR, 59: highest valid register address; valid range is 1..MAX_ADDR, and address 0 is reserved.
- FILL_BYTE, 8'hFF: byte loaded for invalid-address reads and underruns.
- sclk  in  1  clock; all logic is on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- frame_end  in  1  synchronous end-of-frame pulse (sclk stopped / frame closed); highest priority.
- byte_valid  in  1  one-cycle pulse; byte_data holds a complete received byte.
- byte_data  in  8  received byte.
- wr_en  out  1  one-cycle register write strobe.
- wr_addr  out  8  write address, valid with wr_en.
- wr_data  out  8  write data, valid with wr_en.
- rd_req  out  1  read fetch request, held until acknowledged.
- rd_addr  out  8  read address, stable while rd_req=1 unless an underrun occurs.
- rd_ack  in  1  register file has rd_data valid this cycle.
- rd_data  in  8  read data.
- tx_byte  out  8  next byte for the output shifter.
- tx_load  out  1  one-cycle pulse; tx_byte has been updated.
- busy  out  1  high in any state other than IDLE.
- byte_cnt  out  8  data bytes received since the command byte; saturates at 255.
- err_addr  out  1  sticky; an access was made to address 0 or above MAX_ADDR.
- err_underrun  out  1  sticky; byte_valid arrived before a read fetch completed.
- err_clr  in  1  synchronous clear of both sticky flags.

## Operation
- States: IDLE, WRITE, RD_REQ, RD_HOLD.
- Address increment rule: next(a) = 1 if a >= MAX_ADDR, else a+1. The pointer is 8 bits; the command supplies a zero-extended 7-bit value.
- A valid address satisfies 1 <= a <= MAX_ADDR.
- IDLE, on byte_valid:
  - ptr <= {0, byte_data[6:0]} and byte_cnt <= 0.
  - If byte_data[7]=0, go to WRITE.
  - If byte_data[7]=1, go to RD_REQ.
- WRITE, on byte_valid:
  - Valid ptr: wr_en=1 next cycle with wr_addr=ptr and wr_data=byte_data.
  - Invalid ptr: no wr_en; set err_addr.
  - In both cases ptr <= next(ptr) and byte_cnt increments.
- RD_REQ with a valid ptr:
  - rd_req=1 and rd_addr=ptr.
  - On rd_ack: tx_byte <= rd_data, tx_load pulses, rd_req drops, ptr <= next(ptr), go to RD_HOLD.
- RD_REQ with an invalid ptr:
  - No rd_req.
  - Next cycle: tx_byte <= FILL_BYTE, tx_load pulses, err_addr is set, ptr <= next(ptr), go to RD_HOLD.
- RD_REQ, byte_valid before rd_ack (underrun):
  - err_underrun is set; tx_byte <= FILL_BYTE and tx_load pulses.
  - ptr <= next(ptr), byte_cnt increments, stay in RD_REQ.
  - rd_req stays high and rd_addr changes to the new ptr; the requester samples rd_addr together with rd_ack.
  - If rd_ack and byte_valid occur in the same cycle, rd_ack wins: this is a normal completion and byte_cnt increments.
- RD_HOLD, on byte_valid: byte_cnt increments and the state returns to RD_REQ. Received data during a read is ignored.
- frame_end, in any state:
  - Go to IDLE; rd_req=0; ptr=0; byte_cnt=0.
  - A wr_en already registered still issues.
  - tx_byte and the sticky flags hold their values.
- err_clr clears the sticky flags. If a set condition occurs in the same cycle, the set wins.
- byte_valid in the same cycle as frame_end is dropped.

## Timing
- Reset values: all outputs 0 (tx_byte=8'h00); state IDLE; ptr=0.
- Write latency: byte_valid sampled at edge N produces wr_en high from edge N+1 to edge N+2.
- Read: rd_req rises at the edge after the command byte (or after the RD_HOLD byte) is sampled.
  - rd_ack may arrive in the same cycle as rd_req.
  - tx_load rises at the edge after rd_ack is sampled.
  - Underrun-free operation requires rd_ack within 6 cycles of rd_req, given 8 sclk per byte.
- busy goes to 0 at the edge after frame_end is sampled.
- Back-to-back byte_valid (every cycle) must be accepted in WRITE without loss.

## Test plan
- Write burst: command 0x05, then bytes AA,BB,CC -> wr_en 3 times at addresses 5,6,7 with data AA,BB,CC; byte_cnt=3; no errors.
- Write wrap: command 0x3A (58), then 4 bytes -> writes at 58,59,1,2; address 0 is never written.
- Read with rd_ack 2 cycles late: command 0x8A, then 2 dummy bytes -> rd_addr sequence 10,11,12; tx_byte follows rd_data; tx_load 3 times; err_underrun=0.
- Underrun: command 0x84, rd_ack withheld, byte_valid arrives -> tx_byte=FF, err_underrun=1, rd_addr=5; err_clr clears it the next cycle.
- Invalid address: write command 0x7F plus 1 byte -> no wr_en, err_addr=1. Read command 0x80 -> tx_byte=FF, no rd_req, next rd_addr=1.
- frame_end during RD_REQ -> IDLE the next cycle, rd_req=0, busy=0. Asserting rstn mid-burst -> all outputs 0 immediately.
